dotmatix_capture: RTL
=====================

# dotmatix_capture

Receive-side monitor for the row-scanned 7×30 dot-matrix interface. It samples the row strobe and six 5-bit active-low column groups that the display driver emits, and waits for each row to be stable before latching it. It rebuilds complete frames in a double buffer, flags protocol violations, and exposes the last complete frame through a registered read port. It sits beside the display driver on the same clock, for self-check and loopback test.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples (row and all columns) required before a row is latched; legal range 2..65535.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- DMAXRow  in  7  row strobe, one-hot active-high; bit n selects row n; all-zero means blank.
- DMAXCol0..DMAXCol5  in  5 each  column groups, active-low (0 = pixel on).
- rd_row  in  3  row index of the captured frame to read.
- rd_data  out  30  pixel data, 1 = on; [4:0]=~DMAXCol0 … [29:25]=~DMAXCol5; registered.
- frame_valid  out  1  one-cycle pulse when a complete frame is committed to the shadow buffer.
- frame_count  out  8  committed frames, modulo 256.
- err_row  out  1  one-cycle pulse: settled row strobe has more than one bit set.
- err_seq  out  1  one-cycle pulse: settled row arrived out of order.

## Operation
- Input stage: all 37 input bits are registered once (in_q). A stability counter clears whenever in_q differs from the previous in_q, and otherwise increments, saturating.
- States:
  - HOLD (reset state): waits for in_q.row to change. A change to one-hot goes to SETTLE. A change to all-zero stays in HOLD silently. A change to multi-bit pulses err_row and stays in HOLD.
  - SETTLE: any change in row or columns restarts the count on the new candidate. A change to non-one-hot returns to HOLD with the same rules as above. When the count reaches STABLE_CYCLES−1, the candidate is latched and the state returns to HOLD.
- Latch, with idx = row index and exp = expected index (reset 0):
  - idx == exp: write the inverted columns to working[idx]; exp ← exp+1.
  - idx == exp and idx == 6: additionally copy working (including this row) to shadow, pulse frame_valid, increment frame_count, set exp ← 0.
  - idx != exp and idx == 0: pulse err_seq, write working[0], set exp ← 1 (resynchronise).
  - idx != exp otherwise: pulse err_seq, discard the row, set exp ← 0.
- A row held longer than STABLE_CYCLES is latched exactly once. Re-latching requires a row change.
- Read: rd_data ← shadow[rd_row] each cycle. rd_row values 7 and above return 0.

## Timing
- Reset values: rd_data, frame_count, working, shadow, in_q and exp are all 0. frame_valid, err_row and err_seq are 0. State is HOLD.
- A row value first present at the ports before edge E0 and held unchanged is latched at edge E0+STABLE_CYCLES. The resulting frame_valid or err_seq is high in the cycle that follows.
- err_row is high in the cycle after the edge at which the multi-bit value enters in_q, plus one.
- Read latency is 1 cycle. A read sampled on the same edge as a shadow commit returns the pre-commit data.
- frame_count wraps 255 → 0.
- err_row and err_seq never coincide.
- Reset mid-frame discards the partial frame and clears the shadow buffer.

## Configuration
- DMAXCAP_ERRCNT_EN defined: adds output err_count[7:0]. It resets to 0, increments by 1 on each err_row or err_seq pulse, and saturates at 255.
- Undefined: the port and counter are absent. err_row and err_seq behave identically in both builds.

## Structure
- dmaxcap_pkg holds:
  - constants: ROWS=7, GROUPS=6, GROUP_W=5, ROW_W=30;
  - the HOLD/SETTLE state enum;
  - the onehot7-to-index and is-onehot functions.
- Sub-module dmaxcap_stable_filter contains the input register, change detect and stability counter (parameter STABLE_CYCLES). It outputs in_q, changed and stable.

## Test plan
- Drive rows 0..6 in order, each held 10 cycles, with row 1 columns 10001/11010/00101/01000/10001/01000 and all other rows 11111. Required: one frame_valid pulse and frame_count=1. rd_row=1 returns 10111_01110_10111_11010_00101_01110. rd_row=0 returns 0.
- Toggle a column bit every 2 cycles while row 3 is held, with STABLE_CYCLES=4. Required: no latch until the column has been steady for 4 samples; then exactly one write.
- Drive DMAXRow=0000101 for 5 cycles. Required: err_row high for exactly 1 cycle; buffers unchanged.
- Drive rows 0,1,3. Required: err_seq on row 3, exp returns to 0, and no frame_valid. Then rows 0..6 in order produce frame_valid.
- Assert rst after row 4 of a frame, then send rows 5,6. Required: no frame_valid, err_seq on row 5, and rd_data returns 0 for every row.
- With DMAXCAP_ERRCNT_EN defined, inject 300 err_row events. Required: err_count=255.

Source files
------------

// File: rtl/dmaxcap_pkg.sv
// Shared constants, FSM state type and row-strobe decode helpers for dotmatix_capture.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmaxcap_pkg;

    localparam int ROWS    = 7;
    localparam int GROUPS  = 6;
    localparam int GROUP_W = 5;
    localparam int ROW_W   = GROUPS * GROUP_W;
    localparam int IN_W    = ROWS + ROW_W;

    typedef enum logic {
        ST_HOLD   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    // One registered sample of the display interface: strobe plus raw active-low columns.
    typedef struct packed {
        logic [ROWS-1:0]  row;
        logic [ROW_W-1:0] col;
    } sample_t;

    function automatic logic is_onehot7(input logic [ROWS-1:0] r);
        return (r != '0) && ((r & (r - 7'd1)) == '0);
    endfunction

    function automatic logic [2:0] onehot7_to_idx(input logic [ROWS-1:0] r);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < ROWS; i++) begin
            if (r[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmaxcap_stable_filter.sv
// Registers the 37 interface bits once and counts consecutive identical samples.
// Latency: in_q is 1 cycle after the ports; stable fires on the edge that completes STABLE_CYCLES samples.
// Backpressure: none; free-running every cycle.
module dmaxcap_stable_filter
    import dmaxcap_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_raw,
    output logic [IN_W-1:0] in_q,
    output logic            changed,
    output logic            row_changed,
    output logic            stable
);

    localparam logic [15:0] LATCH_AT = 16'(STABLE_CYCLES - 1);

    logic [IN_W-1:0] in_d;
    logic [IN_W-1:0] prev_q, prev_d;
    logic [15:0]     cnt_q, cnt_d;

    // Change detect against the previous sample; counter restarts on change and saturates.
    always_comb begin
        in_d        = in_raw;
        prev_d      = in_q;
        changed     = (in_q != prev_q);
        row_changed = (in_q[IN_W-1:ROW_W] != prev_q[IN_W-1:ROW_W]);
        cnt_d       = cnt_q;
        if (changed) begin
            cnt_d = 16'd0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Equality (not >=) so a long-held value reports stable exactly once.
        stable = !changed && (cnt_d == LATCH_AT);
    end

    // Input, history and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            in_q   <= in_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dotmatix_capture.sv
// Rebuilds 7x30 dot-matrix frames from the row-scanned display bus; flags bad strobes and out-of-order rows.
// Latency: row latched STABLE_CYCLES edges after it reaches the ports; pulses 1 cycle later; read port 1 cycle.
// Backpressure: none; pure monitor. Optional DMAXCAP_ERRCNT_EN adds a saturating err_count output.
module dotmatix_capture
    import dmaxcap_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  DMAXRow,
    input  logic [4:0]  DMAXCol0,
    input  logic [4:0]  DMAXCol1,
    input  logic [4:0]  DMAXCol2,
    input  logic [4:0]  DMAXCol3,
    input  logic [4:0]  DMAXCol4,
    input  logic [4:0]  DMAXCol5,
    input  logic [2:0]  rd_row,
    output logic [29:0] rd_data,
    output logic        frame_valid,
    output logic [7:0]  frame_count,
    output logic        err_row,
`ifdef DMAXCAP_ERRCNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        err_seq
);

    logic [IN_W-1:0]  in_raw;
    logic [IN_W-1:0]  in_q_w;
    logic             changed;
    logic             row_changed;
    logic             stable;
    sample_t          smp;
    logic [ROW_W-1:0] cols_on;
    logic [2:0]       idx;

    state_e           state_q;
    logic [2:0]       exp_q;
    logic [ROW_W-1:0] working_q [ROWS];
    logic [ROW_W-1:0] shadow_q  [ROWS];
    logic             frame_valid_q;
    logic [7:0]       frame_count_q;
    logic             err_row_q;
    logic             err_seq_q;
    logic [ROW_W-1:0] rd_data_q, rd_data_d;

    assign in_raw = {DMAXRow, DMAXCol5, DMAXCol4, DMAXCol3, DMAXCol2, DMAXCol1, DMAXCol0};

    dmaxcap_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .in_raw      (in_raw),
        .in_q        (in_q_w),
        .changed     (changed),
        .row_changed (row_changed),
        .stable      (stable)
    );

    // Decode the settled sample: pixels are stored active-high.
    always_comb begin
        smp     = sample_t'(in_q_w);
        cols_on = ~smp.col;
        idx     = onehot7_to_idx(smp.row);
    end

    // Capture FSM: arm on a row change, latch once when settled, sequence rows into working/shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HOLD;
            exp_q         <= 3'd0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
            err_row_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                working_q[i] <= '0;
                shadow_q[i]  <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            err_row_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (row_changed) begin
                        if (is_onehot7(smp.row)) begin
                            state_q <= ST_SETTLE;
                        end else if (smp.row != '0) begin
                            err_row_q <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (row_changed && !is_onehot7(smp.row)) begin
                        state_q <= ST_HOLD;
                        if (smp.row != '0) err_row_q <= 1'b1;
                    end else if (!changed && stable) begin
                        state_q <= ST_HOLD;
                        if (idx == exp_q) begin
                            working_q[idx] <= cols_on;
                            if (idx == 3'(ROWS - 1)) begin
                                // Commit includes the row being written this cycle.
                                for (int i = 0; i < ROWS - 1; i++) begin
                                    shadow_q[i] <= working_q[i];
                                end
                                shadow_q[ROWS-1] <= cols_on;
                                frame_valid_q    <= 1'b1;
                                frame_count_q    <= frame_count_q + 8'd1;
                                exp_q            <= 3'd0;
                            end else begin
                                exp_q <= exp_q + 3'd1;
                            end
                        end else if (idx == 3'd0) begin
                            // Row 0 out of turn starts a fresh frame.
                            err_seq_q    <= 1'b1;
                            working_q[0] <= cols_on;
                            exp_q        <= 3'd1;
                        end else begin
                            err_seq_q <= 1'b1;
                            exp_q     <= 3'd0;
                        end
                    end
                end
                default: state_q <= ST_HOLD;
            endcase
        end
    end

    // Read mux: out-of-range rows read as blank.
    always_comb begin
        rd_data_d = '0;
        if (int'(rd_row) < ROWS) rd_data_d = shadow_q[rd_row];
    end

    // Registered read port; sees pre-commit shadow on a commit edge.
    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

`ifdef DMAXCAP_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count of error pulses.
    always_comb begin
        err_count_d = err_count_q;
        if ((err_row_q || err_seq_q) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) err_count_q <= 8'd0;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign err_row     = err_row_q;
    assign err_seq     = err_seq_q;

endmodule
